timer_irq_ctrl: RTL and testbench

//  Interrupt and event-capture stage downstream of the 4-channel timer/PWM counter.

---
 rtl/timer_irq_ctrl.sv | 113 +++++++++++
 tb/tb_timer_irq_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt/event-capture stage: per-channel rising-edge detect, sticky pending/overrun,
// saturating event counters, and a small register bus with a level irq.

module timer_irq_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tin,
  input  logic             clr_pend,
  input  logic             clr_ovr,
  input  logic             clr_cnt,
  output logic             pend,
  output logic             ovr,
  output logic [CNT_W-1:0] cnt
);
  logic prev, ev;

  assign ev = tin & ~prev;

  // prev resets high so a line already asserted at reset release is not an event
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b1;
      pend <= 1'b0;
      ovr  <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= tin;
      pend <= ev | (pend & ~clr_pend);
      ovr  <= (ev & pend & ~clr_pend) | (ovr & ~clr_ovr);
      if (clr_cnt)
        cnt <= '0;
      else if (ev && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module timer_irq_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] timer_in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [3:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              irq
);
  localparam logic [3:0] A_PEND = 4'h0;
  localparam logic [3:0] A_EN   = 4'h1;
  localparam logic [3:0] A_OVR  = 4'h2;
  localparam int         A_CNT0 = 3;

  logic [NUM_CH-1:0]            pend, ovr, en;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [31:0]                  rd_mux;
  logic                         wr_pend, wr_ovr, wr_ena;
  logic                         unused_wdata;

  assign wr_pend      = wr_en && (addr == A_PEND);
  assign wr_ovr       = wr_en && (addr == A_OVR);
  assign wr_ena       = wr_en && (addr == A_EN);
  assign unused_wdata = ^wdata[31:NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    timer_irq_lane #(.CNT_W(CNT_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .tin      (timer_in[i]),
      .clr_pend (wr_pend & wdata[i]),
      .clr_ovr  (wr_ovr & wdata[i]),
      .clr_cnt  (wr_en && (addr == 4'(A_CNT0 + i))),
      .pend     (pend[i]),
      .ovr      (ovr[i]),
      .cnt      (cnt[i])
    );
  end

  // Read mux sees register state before any same-cycle write or event
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_PEND:  rd_mux[NUM_CH-1:0] = pend;
      A_EN:    rd_mux[NUM_CH-1:0] = en;
      A_OVR:   rd_mux[NUM_CH-1:0] = ovr;
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (addr == 4'(A_CNT0 + i)) rd_mux[CNT_W-1:0] = cnt[i];
      end
    endcase
  end

  // irq lags the registered pending/enable by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= '0;
      irq    <= 1'b0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wr_ena) en <= wdata[NUM_CH-1:0];
      irq    <= |(pend & en);
      rvalid <= rd_en;
      rdata  <= rd_en ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl (NUM_CH=4, CNT_W=4) with hand-computed expectations.

module tb_timer_irq_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  timer_in;
  logic        wr_en, rd_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid, irq;
  int          n_tests = 0;
  int          n_fail  = 0;

  timer_irq_ctrl #(.NUM_CH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .timer_in(timer_in), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0; wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; timer_in = 4'b0001; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // 1: line held high across reset release is not an event
    reset = 1'b0;
    repeat (3) tick();
    rd_chk("t1_pend", 4'h0, 32'h0);
    rd_chk("t1_cnt0", 4'h3, 32'h0);
    chk("t1_irq", {31'b0, irq}, 32'h0);

    // 2: rising edge on ch0 -> pending, irq one edge later; W1C drops irq two edges after write
    timer_in = 4'b0000;
    tick();
    wr(4'h1, 32'h1);
    timer_in = 4'b0001;
    tick();
    chk("t2_irq_n", {31'b0, irq}, 32'h0);
    tick();
    chk("t2_irq_n1", {31'b0, irq}, 32'h1);
    rd_chk("t2_pend", 4'h0, 32'h1);
    rd_chk("t2_cnt0", 4'h3, 32'h1);
    wr(4'h0, 32'h1);
    chk("t2_irq_w", {31'b0, irq}, 32'h1);
    tick();
    chk("t2_irq_w1", {31'b0, irq}, 32'h0);
    timer_in = 4'b0000;
    tick();

    // 3: event wins over W1C; second event while pending -> overrun
    timer_in = 4'b0100;
    wr(4'h0, 32'h4);
    rd_chk("t3_pend", 4'h0, 32'h4);
    rd_chk("t3_ovr0", 4'h2, 32'h0);
    timer_in = 4'b0000;
    tick();
    timer_in = 4'b0100;
    tick();
    rd_chk("t3_ovr1", 4'h2, 32'h4);
    chk("t3_irq", {31'b0, irq}, 32'h0);
    wr(4'h2, 32'h4);
    rd_chk("t3_ovr_clr", 4'h2, 32'h0);
    timer_in = 4'b0000;
    wr(4'h0, 32'h4);

    // 4: ch3 counter saturates at 15; write coincident with event clears and drops it
    for (int i = 0; i < 7; i++) begin
      timer_in[3] = 1'b1; tick();
      timer_in[3] = 1'b0; tick();
    end
    rd_chk("t4_cnt7", 4'h6, 32'd7);
    for (int i = 0; i < 13; i++) begin
      timer_in[3] = 1'b1; tick();
      timer_in[3] = 1'b0; tick();
    end
    rd_chk("t4_cnt_sat", 4'h6, 32'd15);
    timer_in[3] = 1'b1;
    wr(4'h6, 32'h0);
    rd_chk("t4_cnt_clr", 4'h6, 32'd0);
    timer_in[3] = 1'b0;
    tick();

    // 5: read returns pre-write value; W1C same cycle; unmapped address reads 0
    wr(4'h0, 32'hF);
    timer_in = 4'b0101;
    tick();
    rd_en = 1'b1; wr_en = 1'b1; addr = 4'h0; wdata = 32'hF;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
    chk("t5_rvalid", {31'b0, rvalid}, 32'h1);
    chk("t5_rdata", rdata, 32'h5);
    tick();
    chk("t5_rvalid_drop", {31'b0, rvalid}, 32'h0);
    chk("t5_rdata_idle", rdata, 32'h0);
    rd_chk("t5_pend_clr", 4'h0, 32'h0);
    rd_chk("t5_unmapped", 4'hF, 32'h0);
    rd_chk("t5_en", 4'h1, 32'h1);
    rd_chk("t5_cnt0", 4'h3, 32'h2);

    // 6: reset during an rvalid pulse clears everything next edge
    timer_in = 4'b0000;
    tick();
    timer_in = 4'b1111;
    wr(4'h1, 32'hF);
    tick();
    chk("t6_irq_pre", {31'b0, irq}, 32'h1);
    rd_en = 1'b1; addr = 4'h0;
    tick();
    chk("t6_rvalid_pre", {31'b0, rvalid}, 32'h1);
    chk("t6_rdata_pre", rdata, 32'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0; rd_en = 1'b0;
    chk("t6_rdata", rdata, 32'h0);
    chk("t6_rvalid", {31'b0, rvalid}, 32'h0);
    chk("t6_irq", {31'b0, irq}, 32'h0);
    tick();
    rd_chk("t6_pend", 4'h0, 32'h0);
    rd_chk("t6_en", 4'h1, 32'h0);
    rd_chk("t6_cnt0", 4'h3, 32'h0);
    rd_chk("t6_cnt3", 4'h6, 32'h0);
    chk("t6_irq_post", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
